voice_play_sched: RTL and testbench

- Playback-side scheduler for the SDRAM voice FIFO.
- Issues one-wave read requests (`o_fifo_rd`) to the FIFO and captures the returned samples into a two-bank ping-pong buffer.
- Plays samples out at the audio sample-tick rate.
- Handles read failure, timeout and underrun (silence insertion) so that the DAC side never stalls.

---
 rtl/voice_pkg.sv | 23 ++
 rtl/pingpong_buf.sv | 50 +++++
 rtl/voice_play_sched.sv | 207 ++++++++++++++++++++
 tb/tb_voice_play_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/voice_pkg.sv
// -----------------------------------------------------------------------------
// voice_pkg
// Shared definitions for the voice playback path: request FSM state encodings
// and the default sample width / wave size shared with the SDRAM voice FIFO.
// No ports (package).
// -----------------------------------------------------------------------------
package voice_pkg;

  // Sample width; matches the FIFO data width.
  localparam int DEF_DATA_WIDTH = 16;

  // log2 of samples per wave; the FIFO's WAVE_SIZE is 2**DEF_WAVE_POW.
  localparam int DEF_WAVE_POW = 4;

  // One-hot request FSM encoding.
  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_REQ     = 4'b0010,
    S_WAIT    = 4'b0100,
    S_BACKOFF = 4'b1000
  } state_t;

endpackage

// File: rtl/pingpong_buf.sv
// -----------------------------------------------------------------------------
// pingpong_buf
// Two-bank sample store, 2 x 2**WAVE_POW words. The MSB of each address selects
// the bank. One write port (FIFO fill side) and one registered read port
// (playout side). The read register only updates on rd_en, so it holds the
// last sample between audio ticks; rd_zero loads silence instead of RAM data.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset (read register only)
//   wr_en/wr_addr/wr_data  write port
//   rd_en/rd_zero/rd_addr  read request (rd_zero forces a zero sample)
//   rd_data               registered read data
// -----------------------------------------------------------------------------
module pingpong_buf
  import voice_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WAVE_POW   = DEF_WAVE_POW
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         wr_en,
  input  logic [WAVE_POW:0]            wr_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic                         rd_en,
  input  logic                         rd_zero,
  input  logic [WAVE_POW:0]            rd_addr,
  output logic signed [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** (WAVE_POW + 1);

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage carries no reset: bank validity is tracked by the owner.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? '0 : mem[rd_addr];
    end
  end

endmodule

// File: rtl/voice_play_sched.sv
// -----------------------------------------------------------------------------
// voice_play_sched
// Playback-side scheduler for the SDRAM voice FIFO. A request FSM fetches one
// wave (2**WAVE_POW samples) at a time into whichever ping-pong bank is empty;
// an independent playout path emits one sample per audio tick from the bank
// that is full, inserting silence (and counting an underrun) when none is.
// Read failures, short waves and timeouts back off and retry so the DAC side
// never stalls.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_play_en           playback enable (level); low while idle flushes banks
//   i_sample_tick       one pulse per audio sample period
//   o_fifo_rd           one-cycle wave read request
//   i_fifo_rd_data/ef   returned sample and its valid strobe
//   i_fifo_rd_done      wave read complete
//   i_fifo_rd_fail      wave read failed
//   o_sample            registered output sample
//   o_sample_valid      pulse one cycle after each enabled tick
//   o_underrun          pulse with o_sample_valid when silence is inserted
//   o_underrun_cnt      saturating underrun count
//   o_busy              FIFO request outstanding
// -----------------------------------------------------------------------------
module voice_play_sched
  import voice_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WAVE_POW   = DEF_WAVE_POW,
  parameter int RD_TIMEOUT = 255,
  parameter int RETRY_GAP  = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_play_en,
  input  logic                         i_sample_tick,
  output logic                         o_fifo_rd,
  input  logic signed [DATA_WIDTH-1:0] i_fifo_rd_data,
  input  logic                         i_fifo_rd_ef,
  input  logic                         i_fifo_rd_done,
  input  logic                         i_fifo_rd_fail,
  output logic signed [DATA_WIDTH-1:0] o_sample,
  output logic                         o_sample_valid,
  output logic                         o_underrun,
  output logic [15:0]                  o_underrun_cnt,
  output logic                         o_busy
);

  localparam int WAVE_SIZE = 1 << WAVE_POW;
  localparam int TMO_W     = $clog2(RD_TIMEOUT + 1);
  localparam int GAP_W     = $clog2(RETRY_GAP + 1);

  localparam logic [WAVE_POW:0] FILL_MAX = (WAVE_POW + 1)'(WAVE_SIZE);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(RD_TIMEOUT);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(RETRY_GAP - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Request side state
  state_t              state;
  state_t              state_nxt;
  logic                fill_bank;
  logic [WAVE_POW:0]   fill_idx;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [GAP_W-1:0]    gap_cnt;

  // Shared bank status and playout state
  logic [1:0]          bank_full;
  logic [1:0]          bank_full_nxt;
  logic                play_bank;
  logic [WAVE_POW-1:0] play_idx;
  logic                vld_p1;
  logic                under_p1;
  logic [15:0]         under_cnt;

  logic                beat_ok;
  logic [WAVE_POW:0]   fill_cnt_eff;
  logic                fill_ok;
  logic                fill_bad;
  logic                flush;
  logic                play_hit;
  logic                play_miss;
  logic                play_wrap;

  // Beats beyond a full wave are dropped; fill_idx stops at WAVE_SIZE.
  assign beat_ok      = (state == S_WAIT) && i_fifo_rd_ef && (fill_idx != FILL_MAX);
  assign fill_cnt_eff = fill_idx + {{WAVE_POW{1'b0}}, beat_ok};

  // A done only counts as success when the wave is complete, counting a beat
  // that lands in the same cycle. Everything else that ends the wait is a
  // failure and the partial bank is discarded.
  assign fill_ok  = (state == S_WAIT) && i_fifo_rd_done && !i_fifo_rd_fail &&
                    (fill_cnt_eff == FILL_MAX);
  assign fill_bad = (state == S_WAIT) && !fill_ok &&
                    (i_fifo_rd_fail || i_fifo_rd_done || (tmo_cnt == TMO_LAST));

  // An in-flight SDRAM read cannot be aborted, so flushing waits for S_IDLE.
  assign flush = !i_play_en && (state == S_IDLE);

  assign play_hit  = i_sample_tick && i_play_en &&  bank_full[play_bank];
  assign play_miss = i_sample_tick && i_play_en && !bank_full[play_bank];
  assign play_wrap = play_hit && (play_idx == {WAVE_POW{1'b1}});

  always_comb begin
    state_nxt = state;
    o_fifo_rd = 1'b0;
    o_busy    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_play_en && !bank_full[fill_bank]) state_nxt = S_REQ;
      end
      S_REQ: begin
        o_fifo_rd = 1'b1;
        o_busy    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        o_busy = 1'b1;
        if (fill_ok)       state_nxt = S_IDLE;
        else if (fill_bad) state_nxt = S_BACKOFF;
      end
      S_BACKOFF: begin
        if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      fill_bank <= 1'b0;
      fill_idx  <= '0;
      tmo_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= (state == S_BACKOFF) ? gap_cnt + GAP_W'(1) : '0;
      if (flush) begin
        fill_bank <= 1'b0;
        fill_idx  <= '0;
        tmo_cnt   <= '0;
      end else if (state == S_REQ) begin
        fill_idx <= '0;
        tmo_cnt  <= '0;
      end else if (state == S_WAIT) begin
        fill_idx <= (fill_ok || fill_bad) ? '0 : fill_cnt_eff;
        if (tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + TMO_W'(1);
        if (fill_ok) fill_bank <= ~fill_bank;
      end
    end
  end

  // Fill completion and play drain always target different banks, so both
  // updates are applied independently; flush overrides them.
  always_comb begin
    bank_full_nxt = bank_full;
    if (fill_ok)   bank_full_nxt[fill_bank] = 1'b1;
    if (play_wrap) bank_full_nxt[play_bank] = 1'b0;
    if (flush)     bank_full_nxt = '0;
  end

  // ---- stage p0 -> p1: tick accepted, buffer read registered ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bank_full <= '0;
      play_bank <= 1'b0;
      play_idx  <= '0;
      vld_p1    <= 1'b0;
      under_p1  <= 1'b0;
      under_cnt <= '0;
    end else begin
      bank_full <= bank_full_nxt;
      vld_p1    <= play_hit || play_miss;
      under_p1  <= play_miss;
      if (play_miss) under_cnt <= sat_inc16(under_cnt);
      if (flush) begin
        play_bank <= 1'b0;
        play_idx  <= '0;
      end else if (play_hit) begin
        play_idx <= play_idx + WAVE_POW'(1);
        if (play_wrap) play_bank <= ~play_bank;
      end
    end
  end

  pingpong_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .WAVE_POW   (WAVE_POW)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .wr_en   (beat_ok),
    .wr_addr ({fill_bank, fill_idx[WAVE_POW-1:0]}),
    .wr_data (i_fifo_rd_data),
    .rd_en   (play_hit || play_miss),
    .rd_zero (play_miss),
    .rd_addr ({play_bank, play_idx}),
    .rd_data (o_sample)
  );

  assign o_sample_valid = vld_p1;
  assign o_underrun     = under_p1;
  assign o_underrun_cnt = under_cnt;

endmodule

// File: tb/tb_voice_play_sched.sv
module tb_voice_play_sched;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               play_en;
  logic               sample_tick;
  logic               fifo_rd;
  logic signed [15:0] fifo_rd_data;
  logic               fifo_rd_ef;
  logic               fifo_rd_done;
  logic               fifo_rd_fail;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               underrun;
  logic [15:0]        underrun_cnt;
  logic               busy;

  always #5 clk = ~clk;

  voice_play_sched dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_play_en      (play_en),
    .i_sample_tick  (sample_tick),
    .o_fifo_rd      (fifo_rd),
    .i_fifo_rd_data (fifo_rd_data),
    .i_fifo_rd_ef   (fifo_rd_ef),
    .i_fifo_rd_done (fifo_rd_done),
    .i_fifo_rd_fail (fifo_rd_fail),
    .o_sample       (sample),
    .o_sample_valid (sample_valid),
    .o_underrun     (underrun),
    .o_underrun_cnt (underrun_cnt),
    .o_busy         (busy)
  );

  typedef struct {
    logic [15:0] smp;
    logic        und;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   rd_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: counts read requests and checks every output sample.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && fifo_rd === 1'b1) rd_cnt++;
      if (sample_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sample", int'(sample), int'(e.smp));
          check("underrun_flag", int'(underrun), int'(e.und));
          check("valid_latency", cyc, e.at);
        end
      end
    end
  end

  task automatic tick(input logic [15:0] smp, input logic und, input bit expect_out);
    exp_t e;
    @(negedge clk);
    sample_tick = 1'b1;
    if (expect_out) begin
      e.smp = smp;
      e.und = und;
      e.at  = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic wait_rd(input string name, output int at);
    at = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (fifo_rd === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no o_fifo_rd within 600 cycles", name);
    end
  endtask

  task automatic feed(input int n, input logic [15:0] base, input bit done_last,
                      output int done_at);
    done_at = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fifo_rd_ef   = 1'b1;
      fifo_rd_data = base + 16'(i);
      if (done_last && i == n - 1) begin
        fifo_rd_done = 1'b1;
        done_at      = cyc;
      end
    end
    @(negedge clk);
    fifo_rd_ef   = 1'b0;
    fifo_rd_data = '0;
    fifo_rd_done = 1'b0;
    if (!done_last) begin
      fifo_rd_done = 1'b1;
      done_at      = cyc;
      @(negedge clk);
      fifo_rd_done = 1'b0;
    end
  endtask

  initial begin
    int t_rel, r1, r2, r3, r4, r5, r6, r7, r8, d, f;
    rst_n        = 1'b0;
    play_en      = 1'b0;
    sample_tick  = 1'b0;
    fifo_rd_data = '0;
    fifo_rd_ef   = 1'b0;
    fifo_rd_done = 1'b0;
    fifo_rd_fail = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_fifo_rd", int'(fifo_rd), 0);
    check("rst_sample", int'(sample), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_underrun_cnt", int'(underrun_cnt), 0);
    check("rst_busy", int'(busy), 0);

    // First wave into bank0, done on the same cycle as the 16th beat.
    rst_n = 1'b1;
    t_rel = cyc;
    @(negedge clk);
    play_en = 1'b1;
    wait_rd("first_rd", r1);
    check("first_rd_latency", r1 - t_rel, 2);
    check("busy_in_req", int'(busy), 1);
    feed(16, 16'h0100, 1'b1, d);
    check("single_rd_pulse", rd_cnt, 1);
    wait_rd("bank1_rd", r2);
    check("bank1_rd_after_done", r2 - d, 2);

    // Play bank0 out, then underrun on empty bank1.
    for (int i = 0; i < 16; i++) tick(16'h0100 + 16'(i), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    check("underrun_cnt_3", int'(underrun_cnt), 3);

    // bank1 request never answered: timeout plus backoff before retry.
    wait_rd("timeout_retry", r3);
    check("timeout_retry_gap", r3 - r2, 255 + 16 + 3);

    // Explicit failure.
    @(negedge clk);
    fifo_rd_fail = 1'b1;
    f = cyc;
    @(negedge clk);
    fifo_rd_fail = 1'b0;
    check("busy_after_fail", int'(busy), 0);
    tick(16'h0000, 1'b1, 1'b1);
    wait_rd("fail_retry", r4);
    check("fail_retry_gap", r4 - f, 16 + 2);

    // Short wave is discarded.
    feed(10, 16'h0A00, 1'b0, d);
    check("busy_after_short", int'(busy), 0);
    tick(16'h0000, 1'b1, 1'b1);
    wait_rd("short_retry", r5);
    check("short_retry_gap", r5 - d, 16 + 2);

    // Overlong wave: first 16 kept, extra beats dropped.
    feed(18, 16'h0300, 1'b0, d);
    wait_rd("after_long_rd", r6);
    check("after_long_rd_gap", r6 - d, 2);
    for (int i = 0; i < 16; i++) tick(16'h0300 + 16'(i), 1'b0, 1'b1);
    tick(16'h0000, 1'b1, 1'b1);

    // Disable mid-request: request completes, then flush, no new requests.
    @(negedge clk);
    play_en = 1'b0;
    feed(16, 16'h0400, 1'b1, d);
    repeat (40) @(negedge clk);
    check("no_rd_when_disabled", rd_cnt, 6);
    check("idle_busy_disabled", int'(busy), 0);
    tick(16'h0000, 1'b0, 1'b0);
    check("underrun_cnt_kept", int'(underrun_cnt), 6);
    play_en = 1'b1;
    wait_rd("reenable_rd", r7);
    tick(16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    check("underrun_cnt_7", int'(underrun_cnt), 7);

    // Fill bank0, play one sample, then reset in the middle of S_WAIT.
    feed(16, 16'h0500, 1'b1, d);
    wait_rd("bank1_rd_again", r8);
    tick(16'h0500, 1'b0, 1'b1);
    @(negedge clk);
    check("busy_before_reset", int'(busy), 1);
    check("sample_before_reset", int'(sample), 16'h0500);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_fifo_rd", int'(fifo_rd), 0);
    check("midrst_sample", int'(sample), 0);
    check("midrst_valid", int'(sample_valid), 0);
    check("midrst_underrun", int'(underrun), 0);
    check("midrst_underrun_cnt", int'(underrun_cnt), 0);
    check("midrst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    check("all_samples_seen", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
